one_hot_credit_sender: RTL and testbench

Producer-side credit tracker and send stage for a downstream buffer whose occupancy is tracked by a push/pop one-hot chain. It holds one credit per downstream buffer entry in a one-hot chain. It forwards upstream valid/ready transactions as single-cycle push pulses, consuming one credit each, and recovers a credit on every downstream pop (credit_return). A drain state machine blocks new sends until all credits are back, so the pipeline can quiesce for flush or exception handling.

---
 rtl/taiga_types.sv | 10 +
 rtl/one_hot_credit_sender_if.sv | 37 +++
 rtl/one_hot_credit_chain.sv | 50 +++++
 rtl/one_hot_credit_sender.sv | 83 ++++++++
 tb/tb_one_hot_credit_sender.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/taiga_types.sv
// Shared type definitions for the credit sender slice.
package taiga_types;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_e;

endpackage

// File: rtl/one_hot_credit_sender_if.sv
// Producer-side bus of the credit sender: upstream handshake, downstream push,
// credit return, drain control and status. master = the sender, slave = its environment.
interface one_hot_credit_sender_if #(
    parameter int DATA_WIDTH = 32
);
    import taiga_types::*;

    // Handshake: a transfer happens in every cycle where in_valid and in_ready are
    // both 1 at the clock edge; in_ready never depends on in_valid, and out_push is
    // a one-cycle strobe the downstream buffer must accept unconditionally.
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_push;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  credit_return;
    logic                  drain_req;
    logic                  drain_done;
    logic                  credits_none;
    logic                  credits_last;
    logic                  credits_all;
    logic                  credit_error;
    drain_state_e          state;

    modport master (
        input  in_valid, in_data, credit_return, drain_req,
        output in_ready, out_push, out_data, drain_done,
               credits_none, credits_last, credits_all, credit_error, state
    );

    modport slave (
        output in_valid, in_data, credit_return, drain_req,
        input  in_ready, out_push, out_data, drain_done,
               credits_none, credits_last, credits_all, credit_error, state
    );

endinterface

// File: rtl/one_hot_credit_chain.sv
// One-hot credit counter: bit k set means k credits held. Mirrors the receiver's
// occupancy chain in the opposite direction (take shifts down, give shifts up).
module one_hot_credit_chain #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic take,
    input  logic give,
    output logic none,
    output logic last,
    output logic all,
    output logic error
);
    localparam logic [DEPTH:0] CHAIN_RESET = {1'b1, {DEPTH{1'b0}}};

    logic [DEPTH:0] chain_q, chain_d;
    logic           error_q, error_d;

    always_comb begin
        chain_d = chain_q;
        error_d = error_q;
        if (take && !give && !chain_q[0]) begin
            chain_d = chain_q >> 1;
        end else if (give && !take) begin
            // A give with every credit already home is a protocol violation: saturate and flag.
            if (chain_q[DEPTH]) begin
                error_d = 1'b1;
            end else begin
                chain_d = chain_q << 1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= CHAIN_RESET;
            error_q <= 1'b0;
        end else begin
            chain_q <= chain_d;
            error_q <= error_d;
        end
    end

    assign none  = chain_q[0];
    assign last  = chain_q[1];
    assign all   = chain_q[DEPTH];
    assign error = error_q;

endmodule

// File: rtl/one_hot_credit_sender.sv
// Credit-gated send stage: forwards upstream transfers as registered push pulses,
// one credit per push, with a drain FSM that quiesces until every credit is home.
module one_hot_credit_sender #(
    parameter int CREDITS    = 4,
    parameter int DATA_WIDTH = 32
) (
    input logic                     clk,
    input logic                     rst,
    one_hot_credit_sender_if.master bus
);
    import taiga_types::*;

    drain_state_e          state_q, state_d;
    logic                  push_q, push_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic in_ready;
    logic drain_done;
    logic send;
    logic credits_none, credits_last, credits_all, credit_error;

    one_hot_credit_chain #(.DEPTH(CREDITS)) u_chain (
        .clk  (clk),
        .rst  (rst),
        .take (send),
        .give (bus.credit_return),
        .none (credits_none),
        .last (credits_last),
        .all  (credits_all),
        .error(credit_error)
    );

    // in_ready comes only from registered state, so a returned credit is usable the cycle after.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        drain_done = 1'b0;
        unique case (state_q)
            RUN: begin
                in_ready = ~credits_none;
                if (bus.drain_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (!bus.drain_req)                state_d = RUN;
                else if (credits_all && !push_q)   state_d = DONE;
            end
            DONE: begin
                drain_done = 1'b1;
                if (!bus.drain_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        send   = bus.in_valid & in_ready;
        push_d = send;
        data_d = send ? bus.in_data : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            push_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            push_q  <= push_d;
            data_q  <= data_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_push     = push_q;
    assign bus.out_data     = data_q;
    assign bus.drain_done   = drain_done;
    assign bus.credits_none = credits_none;
    assign bus.credits_last = credits_last;
    assign bus.credits_all  = credits_all;
    assign bus.credit_error = credit_error;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_one_hot_credit_sender.sv
// Bench for one_hot_credit_sender: scenario tasks with inline checks plus a
// cycle model feeding an expected-data queue that is drained on every push.
module tb_one_hot_credit_sender;
    import taiga_types::*;

    localparam int CREDITS = 4;
    localparam int DW      = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    one_hot_credit_sender_if #(.DATA_WIDTH(DW)) bus ();

    one_hot_credit_sender #(.CREDITS(CREDITS), .DATA_WIDTH(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] sb_exp;
    int            m_credits;
    drain_state_e  m_state;
    logic          m_push, m_err, m_rdy, m_snd;
    logic [5:0]    sb_flags_exp, sb_flags_got;
    int            pushes;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.credit_return = 1'b0; bus.drain_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_vec++; if (bus.out_push !== 1'b0) begin n_err++; $display("FAIL reset_out_push: got %b want 0", bus.out_push); end
        n_vec++; if (bus.out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %0h want 0", bus.out_data); end
        n_vec++; if ({bus.credits_all, bus.credits_none, bus.credits_last, bus.credit_error, bus.drain_done} !== 5'b10000) begin
            n_err++; $display("FAIL reset_flags: got %b want 10000",
                {bus.credits_all, bus.credits_none, bus.credits_last, bus.credit_error, bus.drain_done});
        end
        n_vec++; if (bus.state !== RUN) begin n_err++; $display("FAIL reset_state: got %0d want %0d", bus.state, RUN); end
    endtask

    task automatic test_fill();
        pushes = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hA0 + i;
            step();
            if (bus.out_push === 1'b1) pushes++;
        end
        n_vec++; if (pushes != CREDITS) begin n_err++; $display("FAIL fill_push_count: got %0d want %0d", pushes, CREDITS); end
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready: got %b want 0", bus.in_ready); end
        n_vec++; if (bus.credits_none !== 1'b1) begin n_err++; $display("FAIL fill_none: got %b want 1", bus.credits_none); end
    endtask

    task automatic test_credit_return();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hB0;
        bus.credit_return = 1'b1;
        step();
        bus.credit_return = 1'b0;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL ret_in_ready: got %b want 1", bus.in_ready); end
        n_vec++; if (bus.out_push !== 1'b0) begin n_err++; $display("FAIL ret_no_early_push: got %b want 0", bus.out_push); end
        step();
        n_vec++; if (bus.out_push !== 1'b1 || bus.out_data !== 32'hB0) begin
            n_err++; $display("FAIL ret_push: got %b/%0h want 1/b0", bus.out_push, bus.out_data);
        end
        n_vec++; if (bus.credits_none !== 1'b1) begin n_err++; $display("FAIL ret_none_again: got %b want 1", bus.credits_none); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.credit_return = 1'b1;
        repeat (2) step();
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hC0 + i;
            step();
            n_vec++; if ({bus.out_push, bus.credits_none, bus.credits_last, bus.credits_all} !== 4'b1000) begin
                n_err++; $display("FAIL steady_%0d: push/none/last/all got %b want 1000", i,
                    {bus.out_push, bus.credits_none, bus.credits_last, bus.credits_all});
            end
        end
        bus.in_valid = 1'b0;
        repeat (2) step();
        bus.credit_return = 1'b0;
        step();
        n_vec++; if (bus.credits_all !== 1'b1 || bus.credit_error !== 1'b0) begin
            n_err++; $display("FAIL steady_refill: all/err got %b%b want 10", bus.credits_all, bus.credit_error);
        end
    endtask

    task automatic test_error();
        bus.credit_return = 1'b1;
        step();
        bus.credit_return = 1'b0;
        n_vec++; if (bus.credits_all !== 1'b1 || bus.credit_error !== 1'b1) begin
            n_err++; $display("FAIL err_set: all/err got %b%b want 11", bus.credits_all, bus.credit_error);
        end
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hD0 + $urandom_range(0, 15);
            step();
        end
        bus.in_valid = 1'b0;
        bus.credit_return = 1'b1;
        repeat (2) step();
        bus.credit_return = 1'b0;
        step();
        n_vec++; if (bus.credits_all !== 1'b1 || bus.credit_error !== 1'b1) begin
            n_err++; $display("FAIL err_sticky: all/err got %b%b want 11", bus.credits_all, bus.credit_error);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hE0 + i;
            step();
        end
        bus.in_valid  = 1'b0;
        bus.drain_req = 1'b1;
        step();
        n_vec++; if (bus.in_ready !== 1'b0 || bus.state !== DRAIN) begin
            n_err++; $display("FAIL drain_enter: ready/state got %b/%0d want 0/%0d", bus.in_ready, bus.state, DRAIN);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hEE;
        bus.credit_return = 1'b1;
        repeat (3) step();
        bus.credit_return = 1'b0;
        n_vec++; if (bus.credits_all !== 1'b1 || bus.drain_done !== 1'b0) begin
            n_err++; $display("FAIL drain_all_home: all/done got %b%b want 10", bus.credits_all, bus.drain_done);
        end
        step();
        n_vec++; if (bus.drain_done !== 1'b1 || bus.state !== DONE) begin
            n_err++; $display("FAIL drain_done: done/state got %b/%0d want 1/%0d", bus.drain_done, bus.state, DONE);
        end
        bus.in_valid  = 1'b0;
        bus.drain_req = 1'b0;
        step();
        n_vec++; if (bus.state !== RUN || bus.in_ready !== 1'b1 || bus.drain_done !== 1'b0) begin
            n_err++; $display("FAIL drain_exit: state/ready/done got %0d/%b/%b want %0d/1/0",
                bus.state, bus.in_ready, bus.drain_done, RUN);
        end
        bus.drain_req = 1'b1;
        step();
        bus.drain_req = 1'b0;
        step();
        n_vec++; if (bus.state !== RUN || bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL drain_abort: state/ready got %0d/%b want %0d/1", bus.state, bus.in_ready, RUN);
        end
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hF0;
        step();
        n_vec++; if (bus.out_push !== 1'b1) begin n_err++; $display("FAIL mid_push_before: got %b want 1", bus.out_push); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (bus.out_push !== 1'b0 || bus.out_data !== '0) begin
            n_err++; $display("FAIL mid_push_dropped: push/data got %b/%0h want 0/0", bus.out_push, bus.out_data);
        end
        n_vec++; if ({bus.credits_all, bus.credit_error, bus.in_ready} !== 3'b101 || bus.state !== RUN) begin
            n_err++; $display("FAIL mid_state: all/err/ready got %b state %0d want 101 state %0d",
                {bus.credits_all, bus.credit_error, bus.in_ready}, bus.state, RUN);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom_range(0, 255);
        step();
        bus.in_valid = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        m_credits = CREDITS; m_state = RUN; m_push = 1'b0; m_err = 1'b0;
        fork
            // Reference model: advances on the same edges as the DUT, queues expected payloads.
            forever begin
                @(posedge clk or posedge rst);
                if (rst) begin
                    m_credits = CREDITS; m_state = RUN; m_push = 1'b0; m_err = 1'b0;
                    exp_q.delete();
                end else begin
                    m_rdy = (m_credits != 0) && (m_state == RUN);
                    m_snd = bus.in_valid && m_rdy;
                    if (m_snd) exp_q.push_back(bus.in_data);
                    case (m_state)
                        RUN:     if (bus.drain_req) m_state = DRAIN;
                        DRAIN:   if (!bus.drain_req) m_state = RUN;
                                 else if (m_credits == CREDITS && !m_push) m_state = DONE;
                        DONE:    if (!bus.drain_req) m_state = RUN;
                        default: m_state = RUN;
                    endcase
                    if (m_snd && !bus.credit_return) m_credits--;
                    else if (bus.credit_return && !m_snd) begin
                        if (m_credits == CREDITS) m_err = 1'b1;
                        else m_credits++;
                    end
                    m_push = m_snd;
                end
            end
            // Scoreboard: every push pops one expected payload; status is cross-checked each cycle.
            forever begin
                @(negedge clk);
                if (!rst) begin
                    n_vec++;
                    if (bus.out_push !== m_push) begin
                        n_err++; $display("FAIL sb_push @%0t: got %b want %b", $time, bus.out_push, m_push);
                    end
                    if (bus.out_push === 1'b1) begin
                        n_vec++;
                        if (exp_q.size() == 0) begin
                            n_err++; $display("FAIL sb_data @%0t: got %0h want none queued", $time, bus.out_data);
                        end else begin
                            sb_exp = exp_q.pop_front();
                            if (bus.out_data !== sb_exp) begin
                                n_err++; $display("FAIL sb_data @%0t: got %0h want %0h", $time, bus.out_data, sb_exp);
                            end
                        end
                    end
                    sb_flags_exp = {(m_credits != 0) && (m_state == RUN), m_credits == 0, m_credits == 1,
                                    m_credits == CREDITS, m_err, m_state == DONE};
                    sb_flags_got = {bus.in_ready, bus.credits_none, bus.credits_last,
                                    bus.credits_all, bus.credit_error, bus.drain_done};
                    n_vec++;
                    if (sb_flags_got !== sb_flags_exp || bus.state !== m_state) begin
                        n_err++; $display("FAIL sb_status @%0t: flags %b state %0d want flags %b state %0d",
                            $time, sb_flags_got, bus.state, sb_flags_exp, m_state);
                    end
                end
            end
        join_none

        test_reset();
        test_fill();
        test_credit_return();
        test_back_to_back();
        test_error();
        test_drain();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
